lab72_soc_nios2_gen2_0_cpu_debug_mon_mem: RTL and testbench
===========================================================

Name: lab72_soc_nios2_gen2_0_cpu_debug_mon_mem

Overview:
- Debug monitor memory stage sitting directly downstream of the debug-slave sysclk block in the clk domain.
- Consumes its jdo bus and take_action/take_no_action strobes, and executes JTAG read/write commands against a small on-chip monitor RAM.
- Returns MonDReg, monitor_ready and monitor_error upstream to the debug-slave tck block.
- Also exposes a CPU-side debug slave port to the same RAM, arbitrated against the JTAG commands.

Parameters:
- ADDR_W, 8, word-address width of the monitor RAM (legal 2..8); depth is 2^ADDR_W 32-bit words.

Ports:
- clk  input  1  system clock, the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- jdo  input  38  command/data word from the sysclk stage.
- take_action_ocimem_a  input  1  one-cycle strobe: address load / control command.
- take_no_action_ocimem_a  input  1  one-cycle strobe: read at current address, then post-increment.
- take_action_ocimem_b  input  1  one-cycle strobe: write, then post-increment.
- address  input  ADDR_W  CPU word address.
- read  input  1  CPU read request.
- write  input  1  CPU write request.
- writedata  input  32  CPU write data.
- byteenable  input  4  CPU byte lanes.
- debugaccess  input  1  CPU access qualifier.
- readdata  output  32  CPU read data.
- waitrequest  output  1  CPU stall.
- MonDReg  output  32  JTAG read data register.
- monitor_ready  output  1  JTAG command complete / idle.
- monitor_error  output  1  sticky: a command was dropped.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset_n is asynchronous and active-low.
- Reset values:
  - state = IDLE, jaddr = 0, MonDReg = 0, monitor_ready = 1, monitor_error = 0, readdata = 0.
  - RAM contents are not reset.
  - Reset mid-operation aborts the operation; no write is committed after reset asserts.
- RAM: single port, synchronous read, 1-cycle latency. Writes honour byte lanes.
- FSM states: IDLE, JRD, CRD.
- take_action_ocimem_a in IDLE:
  - jaddr <= jdo[26+ADDR_W-1:26].
  - If jdo[35]=1, clear monitor_error.
  - If jdo[34]=1, issue a RAM read at the new address and go to JRD with no post-increment. Otherwise stay in IDLE.
- take_no_action_ocimem_a in IDLE: issue a RAM read at jaddr, set the post-increment flag, go to JRD.
- take_action_ocimem_b in IDLE: write jdo[34:3] to jaddr with all lanes enabled, jaddr <= jaddr+1, stay in IDLE.
- Any JTAG command strobe (one that reads or writes) forces monitor_ready <= 0 at that edge.
  - A write sets monitor_ready <= 1 again on the next edge.
  - For a read, the JRD edge does MonDReg <= RAM output, monitor_ready <= 1, jaddr += 1 if the post-increment flag is set, then goes to IDLE.
  - Result: MonDReg is valid one cycle after the strobe edge.
- jaddr wraps modulo 2^ADDR_W (all-ones + 1 = 0).
- Any JTAG strobe while state != IDLE is dropped and sets monitor_error <= 1. monitor_error is sticky.
- Simultaneous strobes in one cycle: priority is ocimem_b > no_action_a > action_a; the losers are dropped and set monitor_error.
- CPU port with debugaccess=1:
  - write in IDLE with no JTAG strobe that cycle: waitrequest = 0 and the write commits at that edge.
  - read in IDLE with no JTAG strobe: waitrequest = 1, RAM read issued, go to CRD. In CRD, readdata = RAM output registered, waitrequest = 0, then return to IDLE.
- CPU arbitration:
  - A JTAG strobe in the same cycle wins; the CPU sees waitrequest = 1 and retries.
  - In JRD the CPU sees waitrequest = 1.
  - JTAG strobes arriving in CRD are dropped with error, per the rule above.
- CPU port with debugaccess=0: waitrequest = 0, readdata = 0, write ignored. The port never hangs.
- With no request, waitrequest = 0 regardless of state, except while in CRD.

Test Plan:
- Reset, then take_action_ocimem_a with jdo[33:26] = 8'h10 and jdo[34] = 0, then take_action_ocimem_b with jdo[34:3] = 32'hDEADBEEF -> RAM[0x10] = DEADBEEF, jaddr = 0x11, monitor_ready pulses low for 1 cycle.
- take_action_ocimem_a with address 0x10 and jdo[34] = 1 -> one cycle later MonDReg = DEADBEEF, monitor_ready = 1, jaddr stays 0x10.
- jaddr = 0xFF, then take_no_action_ocimem_a -> MonDReg = RAM[0xFF] and jaddr wraps to 0x00.
- Read strobe, then a second strobe while in JRD -> second dropped, monitor_error = 1. Then take_action_ocimem_a with jdo[35] = 1 -> monitor_error = 0.
- CPU read at 0x10 in the same cycle as a JTAG write strobe -> JTAG write commits first, CPU waitrequest stays 1. Then CPU readdata = new value with waitrequest low for exactly 1 cycle.
- CPU write with debugaccess = 0 -> waitrequest = 0 and RAM unchanged. Assert reset_n = 0 while in JRD -> immediate IDLE, monitor_ready = 1, MonDReg = 0.

Source files
------------

// File: rtl/lab72_soc_nios2_gen2_0_cpu_debug_mon_mem.sv
// lab72_soc_nios2_gen2_0_cpu_debug_mon_mem -- JTAG/CPU debug monitor RAM with command FSM.
// Revision: 1.0
`default_nettype none

module lab72_soc_nios2_gen2_0_cpu_debug_mon_mem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    JRD  = 2'd1,
    CRD  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] jaddr, jaddr_nxt;
  logic              postinc, postinc_nxt;
  logic [31:0]       mondreg_nxt;
  logic              ready_nxt, error_nxt;
  logic [31:0]       rd_hold, rd_hold_nxt;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [31:0]       ram_q;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;

  logic              is_idle, any_strobe, drop;
  logic              do_b, do_n, do_a, cpu_ok, cpu_wr, cpu_rd;
  logic [ADDR_W-1:0] jdo_addr;
  logic              unused_bits;

  assign unused_bits = ^{jdo[37:36], jdo[2:0]};
  assign jdo_addr    = jdo[26 +: ADDR_W];

  assign is_idle    = (state == IDLE);
  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign do_b = is_idle & take_action_ocimem_b;
  assign do_n = is_idle & ~take_action_ocimem_b & take_no_action_ocimem_a;
  assign do_a = is_idle & ~take_action_ocimem_b & ~take_no_action_ocimem_a & take_action_ocimem_a;

  // In IDLE only the lower-priority losers are dropped; elsewhere every strobe is.
  assign drop = is_idle ?
                ((take_action_ocimem_b & (take_no_action_ocimem_a | take_action_ocimem_a)) |
                 (take_no_action_ocimem_a & take_action_ocimem_a)) :
                any_strobe;

  assign cpu_ok = is_idle & ~any_strobe & debugaccess;
  assign cpu_wr = cpu_ok & write;
  assign cpu_rd = cpu_ok & read & ~write;

  assign waitrequest = debugaccess & (read | write) & (state != CRD) & ~cpu_wr;
  assign readdata    = !debugaccess ? 32'h0 : ((state == CRD) ? ram_q : rd_hold);

  always_comb begin
    state_nxt   = state;
    jaddr_nxt   = jaddr;
    postinc_nxt = postinc;
    mondreg_nxt = MonDReg;
    ready_nxt   = monitor_ready;
    error_nxt   = monitor_error | drop;
    rd_hold_nxt = rd_hold;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = jaddr;
    ram_wdata   = jdo[34:3];
    ram_be      = 4'hF;
    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        if (do_b) begin
          ram_we    = 1'b1;
          jaddr_nxt = jaddr + 1'b1;
          ready_nxt = 1'b0;
        end else if (do_n) begin
          ram_re      = 1'b1;
          postinc_nxt = 1'b1;
          ready_nxt   = 1'b0;
          state_nxt   = JRD;
        end else if (do_a) begin
          jaddr_nxt = jdo_addr;
          if (jdo[35]) error_nxt = 1'b0;
          if (jdo[34]) begin
            ram_addr    = jdo_addr;
            ram_re      = 1'b1;
            postinc_nxt = 1'b0;
            ready_nxt   = 1'b0;
            state_nxt   = JRD;
          end
        end else if (cpu_wr) begin
          ram_we    = 1'b1;
          ram_addr  = address;
          ram_wdata = writedata;
          ram_be    = byteenable;
        end else if (cpu_rd) begin
          ram_re    = 1'b1;
          ram_addr  = address;
          state_nxt = CRD;
        end
      end
      JRD: begin
        mondreg_nxt = ram_q;
        ready_nxt   = 1'b1;
        if (postinc) jaddr_nxt = jaddr + 1'b1;
        state_nxt   = IDLE;
      end
      CRD: begin
        rd_hold_nxt = ram_q;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      jaddr         <= '0;
      postinc       <= 1'b0;
      MonDReg       <= 32'h0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      rd_hold       <= 32'h0;
    end else begin
      state         <= state_nxt;
      jaddr         <= jaddr_nxt;
      postinc       <= postinc_nxt;
      MonDReg       <= mondreg_nxt;
      monitor_ready <= ready_nxt;
      monitor_error <= error_nxt;
      rd_hold       <= rd_hold_nxt;
    end
  end

  // RAM is not reset; the write enable is still qualified so reset blocks commits.
  always_ff @(posedge clk) begin
    if (ram_re) ram_q <= mem[ram_addr];
    for (int i = 0; i < 4; i++) begin
      if (reset_n && ram_we && ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lab72_soc_nios2_gen2_0_cpu_debug_mon_mem.sv
// Directed self-checking bench for the debug monitor memory.
`default_nettype none

module tb_lab72_soc_nios2_gen2_0_cpu_debug_mon_mem;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        ta_a, tna_a, ta_b;
  logic [7:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        debugaccess;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lab72_soc_nios2_gen2_0_cpu_debug_mon_mem #(.ADDR_W(8)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (ta_a),
    .take_no_action_ocimem_a(tna_a),
    .take_action_ocimem_b   (ta_b),
    .address                (address),
    .read                   (read),
    .write                  (write),
    .writedata              (writedata),
    .byteenable             (byteenable),
    .debugaccess            (debugaccess),
    .readdata               (readdata),
    .waitrequest            (waitrequest),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] j_addr(input logic [7:0] a, input logic rd, input logic clr);
    logic [37:0] j;
    j = '0;
    j[33:26] = a;
    j[34] = rd;
    j[35] = clr;
    return j;
  endfunction

  function automatic logic [37:0] j_wr(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    ta_a = 1'b0;
    tna_a = 1'b0;
    ta_b = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; jdo = '0; ta_a = 0; tna_a = 0; ta_b = 0;
    address = '0; read = 0; write = 0; writedata = '0; byteenable = 4'hF; debugaccess = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_ready", {31'h0, monitor_ready}, 32'h1);
    chk("rst_error", {31'h0, monitor_error}, 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_wait", {31'h0, waitrequest}, 32'h0);
    reset_n = 1'b1;

    // Address load then JTAG write
    jdo = j_addr(8'h10, 1'b0, 1'b0); ta_a = 1'b1; tick();
    chk("load_ready", {31'h0, monitor_ready}, 32'h1);
    chk("load_jaddr", {24'h0, dut.jaddr}, 32'h10);
    jdo = j_wr(32'hDEADBEEF); ta_b = 1'b1; tick();
    chk("wr_ready_low", {31'h0, monitor_ready}, 32'h0);
    chk("wr_jaddr_inc", {24'h0, dut.jaddr}, 32'h11);
    tick();
    chk("wr_ready_back", {31'h0, monitor_ready}, 32'h1);
    chk("wr_mem", dut.mem[8'h10], 32'hDEADBEEF);

    // Address load with read, no post-increment
    jdo = j_addr(8'h10, 1'b1, 1'b0); ta_a = 1'b1; tick();
    chk("rd_ready_low", {31'h0, monitor_ready}, 32'h0);
    tick();
    chk("rd_mondreg", MonDReg, 32'hDEADBEEF);
    chk("rd_ready", {31'h0, monitor_ready}, 32'h1);
    chk("rd_jaddr_keep", {24'h0, dut.jaddr}, 32'h10);

    // Write at 0xFF wraps jaddr; then read at 0xFF with post-increment wraps
    jdo = j_addr(8'hFF, 1'b0, 1'b0); ta_a = 1'b1; tick();
    jdo = j_wr(32'h12345678); ta_b = 1'b1; tick();
    chk("wr_wrap", {24'h0, dut.jaddr}, 32'h0);
    jdo = j_addr(8'hFF, 1'b0, 1'b0); ta_a = 1'b1; tick();
    tna_a = 1'b1; tick();
    chk("nrd_ready_low", {31'h0, monitor_ready}, 32'h0);
    tick();
    chk("nrd_mondreg", MonDReg, 32'h12345678);
    chk("nrd_wrap", {24'h0, dut.jaddr}, 32'h0);

    // Strobe during JRD is dropped and flags an error
    jdo = j_addr(8'h10, 1'b1, 1'b0); ta_a = 1'b1; tick();
    tna_a = 1'b1; tick();
    chk("drop_error", {31'h0, monitor_error}, 32'h1);
    chk("drop_mondreg", MonDReg, 32'hDEADBEEF);
    chk("drop_jaddr", {24'h0, dut.jaddr}, 32'h10);
    tick();
    chk("drop_sticky", {31'h0, monitor_error}, 32'h1);
    jdo = j_addr(8'h20, 1'b0, 1'b1); ta_a = 1'b1; tick();
    chk("clear_error", {31'h0, monitor_error}, 32'h0);

    // Simultaneous strobes: write wins, loser flags error
    jdo = j_wr(32'hCAFEF00D); ta_b = 1'b1; ta_a = 1'b1; tick();
    chk("simul_error", {31'h0, monitor_error}, 32'h1);
    chk("simul_jaddr", {24'h0, dut.jaddr}, 32'h21);
    chk("simul_mem", dut.mem[8'h20], 32'hCAFEF00D);
    jdo = j_addr(8'h10, 1'b0, 1'b1); ta_a = 1'b1; tick();
    chk("simul_clear", {31'h0, monitor_error}, 32'h0);

    // CPU read collides with JTAG write: JTAG first, CPU retries
    jdo = j_wr(32'hA5A50F0F); ta_b = 1'b1;
    address = 8'h10; read = 1'b1;
    #1;
    chk("cpu_wait_strobe", {31'h0, waitrequest}, 32'h1);
    tick();
    chk("cpu_wait_issue", {31'h0, waitrequest}, 32'h1);
    tick();
    chk("cpu_crd_wait", {31'h0, waitrequest}, 32'h0);
    chk("cpu_crd_data", readdata, 32'hA5A50F0F);
    tick();
    chk("cpu_wait_one_cycle", {31'h0, waitrequest}, 32'h1);
    read = 1'b0;
    #1;
    chk("cpu_hold_data", readdata, 32'hA5A50F0F);
    chk("cpu_idle_wait", {31'h0, waitrequest}, 32'h0);

    // CPU byte-lane write
    write = 1'b1; writedata = 32'h11223344; byteenable = 4'b0011;
    #1;
    chk("cpu_wr_wait", {31'h0, waitrequest}, 32'h0);
    tick();
    write = 1'b0;
    chk("cpu_wr_lanes", dut.mem[8'h10], 32'hA5A53344);

    // debugaccess=0: write ignored, port never stalls
    debugaccess = 1'b0; write = 1'b1; writedata = 32'h0; byteenable = 4'hF;
    #1;
    chk("nodbg_wait", {31'h0, waitrequest}, 32'h0);
    chk("nodbg_readdata", readdata, 32'h0);
    tick();
    write = 1'b0; debugaccess = 1'b1;
    chk("nodbg_mem", dut.mem[8'h10], 32'hA5A53344);

    // Reset in JRD aborts immediately
    jdo = j_addr(8'h10, 1'b1, 1'b0); ta_a = 1'b1; tick();
    chk("jrd_before_rst", {31'h0, monitor_ready}, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("rst_jrd_state", {30'h0, dut.state}, 32'h0);
    chk("rst_jrd_ready", {31'h0, monitor_ready}, 32'h1);
    chk("rst_jrd_mondreg", MonDReg, 32'h0);
    #20;
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
